dmem_subword_ctrl: RTL and testbench
====================================

Name: dmem_subword_ctrl

Overview:
- Sits between the single-cycle core datapath (ALU address and store-data outputs, read-data input) and a word-wide synchronous SRAM that has no byte enables.
- Implements byte/halfword/word loads (with sign or zero extension) and stores.
- Subword stores use read-modify-write.
- Stalls the core with `stall` until each access completes, and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 6: SRAM word-address width (depth = 2**ADDR_W words).
- XLEN, 32: data width; only 32 is supported.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  memory access this cycle (memread or memwrite); core holds all req_* stable while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends (lbu/lhu) when 1
- addr  in  32  byte address (aluout)
- wdata  in  32  store data, right-aligned (writedata)
- rdata  out  32  aligned and extended load result
- stall  out  1  freeze PC and register-file write while 1
- misalign  out  1  access rejected this cycle
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write
- sram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- sram_wdata  out  32  SRAM write word
- sram_rdata  in  32  SRAM read data, valid one cycle after a read strobe

Behaviour:
- States: IDLE, RD_WAIT, WRITE. Reset (reset==0 at a clk edge) forces IDLE and clears the merge and request registers.
- Outputs are combinational from state and inputs. In IDLE with req_valid=0, every output is 0.
- Byte order is little-endian: lane k = bits 8k+7:8k, selected by addr[1:0]. Halfword lane is selected by addr[1].
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the SRAM size.
- Misalignment is evaluated in IDLE:
  - half with addr[0]=1, word with addr[1:0]!=0, or req_size=11 -> misalign=1, stall=0, sram_en=0, rdata=0.
  - State stays IDLE. The access is consumed in that one cycle.
- Word store: IDLE issues sram_en=1, sram_we=1, sram_wdata=wdata, stall=0. Stays in IDLE. Latency 1 cycle.
- Load:
  - IDLE issues a read (sram_en=1, sram_we=0), stall=1, and latches addr[1:0], size and unsigned; -> RD_WAIT.
  - RD_WAIT: rdata = lane extracted from sram_rdata, then sign- or zero-extended; stall=0; -> IDLE.
  - Latency 2 cycles. Word loads ignore req_unsigned.
- Subword store:
  - IDLE issues a read, stall=1; -> RD_WAIT.
  - RD_WAIT: merge wdata[7:0] or wdata[15:0] into the selected lane of sram_rdata and register the result; stall=1; -> WRITE.
  - WRITE: sram_en=1, sram_we=1, sram_wdata = merged word, stall=0; -> IDLE.
  - Latency 3 cycles. The other lanes are preserved bit-exactly.
- Back-to-back requests: the cycle after stall falls, IDLE accepts a new request. Consecutive accesses to the same word observe the earlier write.
- rdata is 0 in every cycle except a load's RD_WAIT cycle.
- Reset mid-operation: the in-flight access is abandoned. A reset in the WRITE cycle suppresses that write (sram_en=0), so memory keeps its old word. stall=0 while reset is asserted.
- req_valid dropping while stall=1 is a protocol violation; the block completes the latched access regardless.

Decomposition:
- Package dmem_pkg:
  - size_e with SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.
  - state_e with IDLE, RD_WAIT, WRITE.
  - Function is_misaligned(size, addr_lo).
- Sub-module dmem_lane_align (combinational): given a word, addr_lo, size and unsigned, produces the extended load value; also gives merge(word, wdata, addr_lo, size) for stores.
- The FSM and registers stay in dmem_subword_ctrl.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> store takes 1 cycle with stall=0, sram_addr=4; load stalls 1 cycle and returns rdata=0xDEADBEEF.
- sb 0x5A @0x11 after the above, then lw @0x10 -> 3-cycle store with stall high for 2 cycles; word reads back as 0xDEAD5AEF.
- sh 0x8001 @0x12, then lh @0x12 -> 0xFFFF8001; lhu @0x12 -> 0x00008001; lw @0x10 -> 0x80015AEF.
- lb @0x11 -> 0x0000005A; sb 0xA5 @0x13, then lb @0x13 -> 0xFFFFFFA5 and lbu @0x13 -> 0x000000A5.
- lw @0x12, sh @0x13, and req_size=11 -> misalign=1, stall=0, sram_en=0, state stays IDLE, memory unchanged.
- sb 0xFF @0x10 with reset driven low during the WRITE cycle -> no write strobe; after reset release, lw @0x10 returns the prior word unchanged. Addr 0x100 with ADDR_W=6 aliases to word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and helpers for the sub-word data-memory controller.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int c_XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    // Illegal size encodings are reported through the same path as misalignment.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            SZ_HALF: r = addr_lo[0];
            SZ_WORD: r = (addr_lo != 2'b00);
            SZ_ILL:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_subword_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_subword_ctrl_if
// Brief    : Core-side request bus and SRAM-side bus of the data-memory controller.
// Revision : 1.0
// ============================================================================
interface dmem_subword_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 32
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;
    logic              stall;
    logic              misalign;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [XLEN-1:0]   sram_wdata;
    logic [XLEN-1:0]   sram_rdata;

    // Master: core datapath plus SRAM macro; slave: the controller.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, addr, wdata, sram_rdata,
        input  rdata, stall, misalign, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, addr, wdata, sram_rdata,
        output rdata, stall, misalign, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Little-endian lane extract/extend for loads and lane merge for stores.
// Revision : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [c_XLEN-1:0] i_word,
    input  wire logic [c_XLEN-1:0] i_wdata,
    input  wire logic [1:0]        i_addr_lo,
    input  wire size_e             i_size,
    input  wire logic              i_unsigned,
    output logic      [c_XLEN-1:0] o_load,
    output logic      [c_XLEN-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_load = '0;
        case (i_size)
            SZ_BYTE: o_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_load = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SZ_WORD: o_load = i_word;
            default: o_load = '0;
        endcase
    end

    // Only the addressed lane changes; all other bits come from the old word.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_subword_ctrl
// Brief    : Byte/half/word load-store controller over a word-only SRAM (RMW stores).
// Revision : 1.0
// ============================================================================
module dmem_subword_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    dmem_subword_ctrl_if.slave    bus
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_we;
    size_e             r_size;
    logic              r_unsigned;
    logic [1:0]        r_addr_lo;
    logic [ADDR_W-1:0] r_word_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_merged;

    logic              w_capture;
    logic              w_misaligned;
    size_e             w_req_size;
    logic [XLEN-1:0]   w_load_val;
    logic [XLEN-1:0]   w_merged;
    logic              w_unused_addr_hi;

    assign w_req_size       = size_e'(bus.req_size);
    assign w_misaligned     = is_misaligned(w_req_size, bus.addr[1:0]);
    assign w_unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    dmem_lane_align u_lane_align (
        .i_word     (bus.sram_rdata),
        .i_wdata    (r_wdata),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load_val),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_merged    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_we        <= bus.req_we;
                r_size      <= w_req_size;
                r_unsigned  <= bus.req_unsigned;
                r_addr_lo   <= bus.addr[1:0];
                r_word_addr <= bus.addr[ADDR_W+1:2];
                r_wdata     <= bus.wdata;
            end
            if (r_state == RD_WAIT && r_we) begin
                r_merged <= w_merged;
            end
        end
    end

    // Outputs are forced low during reset so an in-flight write is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        bus.rdata      = '0;
        bus.stall      = 1'b0;
        bus.misalign   = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (w_misaligned) begin
                            bus.misalign = 1'b1;
                        end else begin
                            bus.sram_en   = 1'b1;
                            bus.sram_addr = bus.addr[ADDR_W+1:2];
                            if (bus.req_we && w_req_size == SZ_WORD) begin
                                bus.sram_we    = 1'b1;
                                bus.sram_wdata = bus.wdata;
                            end else begin
                                bus.stall   = 1'b1;
                                w_capture   = 1'b1;
                                w_state_nxt = RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_we) begin
                        bus.stall   = 1'b1;
                        w_state_nxt = WRITE;
                    end else begin
                        bus.rdata   = w_load_val;
                        w_state_nxt = IDLE;
                    end
                end
                WRITE: begin
                    bus.sram_en    = 1'b1;
                    bus.sram_we    = 1'b1;
                    bus.sram_addr  = r_word_addr;
                    bus.sram_wdata = r_merged;
                    w_state_nxt    = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_subword_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_subword_ctrl
// Brief    : Directed self-checking bench for dmem_subword_ctrl with an SRAM model.
// Revision : 1.0
// ============================================================================
module tb_dmem_subword_ctrl;
    import dmem_pkg::*;

    localparam int c_ADDR_W = 6;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [31:0] mem [0:(1<<c_ADDR_W)-1];

    dmem_subword_ctrl_if #(.ADDR_W(c_ADDR_W), .XLEN(32)) bus ();

    dmem_subword_ctrl #(.ADDR_W(c_ADDR_W), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-wide synchronous SRAM: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic st, input logic en,
                           input logic we, input logic mis, input logic [31:0] rd);
        chk({tag, ".stall"},    {31'd0, bus.stall},    {31'd0, st});
        chk({tag, ".sram_en"},  {31'd0, bus.sram_en},  {31'd0, en});
        chk({tag, ".sram_we"},  {31'd0, bus.sram_we},  {31'd0, we});
        chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, mis});
        chk({tag, ".rdata"},    bus.rdata,             rd);
    endtask

    // Apply inputs 1 ns after a rising edge, leave time to settle before sampling.
    task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.addr         = a;
        bus.wdata        = wd;
        #3;
    endtask

    task automatic do_sw(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_waddr);
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, a, wd);
        chk_out({tag, ".c1"}, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk({tag, ".sram_addr"},  {26'd0, bus.sram_addr}, exp_waddr);
        chk({tag, ".sram_wdata"}, bus.sram_wdata, wd);
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
        chk_out({tag, ".c1"}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
        chk_out({tag, ".c2"}, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic do_sub_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_word,
                                input logic [31:0] exp_waddr);
        drive(1'b1, 1'b1, sz, 1'b0, a, wd);
        chk_out({tag, ".c1"}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, sz, 1'b0, a, wd);
        chk_out({tag, ".c2"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, sz, 1'b0, a, wd);
        chk_out({tag, ".c3"}, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk({tag, ".sram_wdata"}, bus.sram_wdata, exp_word);
        chk({tag, ".sram_addr"},  {26'd0, bus.sram_addr}, exp_waddr);
    endtask

    task automatic do_misalign(input string tag, input logic we, input logic [1:0] sz,
                               input logic [31:0] a);
        drive(1'b1, we, sz, 1'b0, a, 32'hFFFF_FFFF);
        chk_out(tag, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < (1 << c_ADDR_W); i++) mem[i] = 32'h0;
        bus.sram_rdata = 32'h0;
        reset = 1'b0;

        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        #3 chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        do_sw("sw10", 32'h10, 32'hDEAD_BEEF, 32'd4);
        do_load("lw10a", SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);

        do_sub_store("sb11", SZ_BYTE, 32'h11, 32'h0000_005A, 32'hDEAD_5AEF, 32'd4);
        do_load("lw10b", SZ_WORD, 1'b0, 32'h10, 32'hDEAD_5AEF);

        do_sub_store("sh12", SZ_HALF, 32'h12, 32'h1234_8001, 32'h8001_5AEF, 32'd4);
        do_load("lh12",  SZ_HALF, 1'b0, 32'h12, 32'hFFFF_8001);
        do_load("lhu12", SZ_HALF, 1'b1, 32'h12, 32'h0000_8001);
        do_load("lw10c", SZ_WORD, 1'b0, 32'h10, 32'h8001_5AEF);

        do_load("lb11", SZ_BYTE, 1'b0, 32'h11, 32'h0000_005A);
        do_sub_store("sb13", SZ_BYTE, 32'h13, 32'hFFFF_FFA5, 32'hA501_5AEF, 32'd4);
        do_load("lb13",  SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FFA5);
        do_load("lbu13", SZ_BYTE, 1'b1, 32'h13, 32'h0000_00A5);

        do_misalign("mis_lw12", 1'b0, SZ_WORD, 32'h12);
        do_misalign("mis_sh13", 1'b1, SZ_HALF, 32'h13);
        do_misalign("mis_ill",  1'b1, SZ_ILL,  32'h10);
        do_load("lw10d", SZ_WORD, 1'b0, 32'h10, 32'hA501_5AEF);

        // Store aborted by reset in its WRITE cycle.
        drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h0000_00FF);
        chk_out("rst_sb.c1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h0000_00FF);
        chk_out("rst_sb.c2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #3 chk_out("rst_sb.c3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.req_valid = 1'b0;
        do_load("lw10e", SZ_WORD, 1'b0, 32'h10, 32'hA501_5AEF);

        // Upper address bits wrap onto the 64-word array.
        do_sw("sw100", 32'h100, 32'h1234_5678, 32'd0);
        do_load("lw000", SZ_WORD, 1'b0, 32'h0,   32'h1234_5678);
        do_load("lw110", SZ_WORD, 1'b0, 32'h110, 32'hA501_5AEF);

        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk_out("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
